// File: rtl/decode_dispatch_ctrl.sv
// Instruction buffer and dispatch sequencer feeding the combinational decoder and rename.
// Define DECODE_DISPATCH_PERF_EN to add saturating dispatch / jump-wait stall counters.
module decode_dispatch_ctrl #(
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_valid_i,
    output logic          if_ready_o,
    input  logic [31:0]   if_inst_i,
    input  logic [31:0]   if_pc_i,
    output logic [31:0]   dec_inst_o,
    output logic [31:0]   dec_pc_o,
    input  logic          dec_jump_i,
    output logic          dec_valid_o,
    input  logic          ren_ready_i,
    input  logic          jump_resolved_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o
`ifdef DECODE_DISPATCH_PERF_EN
    ,
    output logic [31:0]   perf_dispatch_o,
    output logic [31:0]   perf_jwait_stall_o
`endif
);

    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {
        RUN   = 1'b0,
        JWAIT = 1'b1
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic empty;
    logic full;
    logic enq;
    logic deq;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CW'(DEPTH));
    assign if_ready_o  = !full;
    assign enq         = if_valid_i && !full && !flush_i;
    assign dec_valid_o = !empty && (state_reg == RUN) && !flush_i;
    assign deq         = dec_valid_o && ren_ready_i;
    assign count_o     = count_reg;

    // Head is read asynchronously so an entry is visible the cycle after it is written.
    assign dec_inst_o = empty ? NOP   : inst_mem[rd_ptr_reg];
    assign dec_pc_o   = empty ? 32'd0 : pc_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[wr_ptr_reg] <= if_inst_i;
            pc_mem[wr_ptr_reg]   <= if_pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= RUN;
        end else begin
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            case (state_reg)
                RUN: begin
                    if (deq && dec_jump_i) begin
                        state_reg <= JWAIT;
                    end
                end
                JWAIT: begin
                    if (jump_resolved_i) begin
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

`ifdef DECODE_DISPATCH_PERF_EN
    logic [31:0] perf_dispatch_reg;
    logic [31:0] perf_jwait_stall_reg;

    // Counters survive flush and stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_dispatch_reg    <= '0;
            perf_jwait_stall_reg <= '0;
        end else begin
            if (deq && (perf_dispatch_reg != '1)) begin
                perf_dispatch_reg <= perf_dispatch_reg + 32'd1;
            end
            if ((state_reg == JWAIT) && !empty && (perf_jwait_stall_reg != '1)) begin
                perf_jwait_stall_reg <= perf_jwait_stall_reg + 32'd1;
            end
        end
    end

    assign perf_dispatch_o    = perf_dispatch_reg;
    assign perf_jwait_stall_o = perf_jwait_stall_reg;
`endif

endmodule

// File: tb/tb_decode_dispatch_ctrl.sv
// Directed bench for decode_dispatch_ctrl with a scoreboard of accepted {pc, inst} pairs.
// Set DECODE_DISPATCH_PERF_EN to also exercise the performance counters.
module tb_decode_dispatch_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          if_valid_i;
    logic          if_ready_o;
    logic [31:0]   if_inst_i;
    logic [31:0]   if_pc_i;
    logic [31:0]   dec_inst_o;
    logic [31:0]   dec_pc_o;
    logic          dec_jump_i;
    logic          dec_valid_o;
    logic          ren_ready_i;
    logic          jump_resolved_i;
    logic          flush_i;
    logic [CW-1:0] count_o;
`ifdef DECODE_DISPATCH_PERF_EN
    logic [31:0]   perf_dispatch_o;
    logic [31:0]   perf_jwait_stall_o;
`endif

    decode_dispatch_ctrl #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .if_valid_i      (if_valid_i),
        .if_ready_o      (if_ready_o),
        .if_inst_i       (if_inst_i),
        .if_pc_i         (if_pc_i),
        .dec_inst_o      (dec_inst_o),
        .dec_pc_o        (dec_pc_o),
        .dec_jump_i      (dec_jump_i),
        .dec_valid_o     (dec_valid_o),
        .ren_ready_i     (ren_ready_i),
        .jump_resolved_i (jump_resolved_i),
        .flush_i         (flush_i),
        .count_o         (count_o)
`ifdef DECODE_DISPATCH_PERF_EN
        ,
        .perf_dispatch_o    (perf_dispatch_o),
        .perf_jwait_stall_o (perf_jwait_stall_o)
`endif
    );

    // Stand-in for the decoder: flags JALR at the head.
    assign dec_jump_i = (dec_inst_o[6:0] == 7'b1100111);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t sb[$];
    bit     m_jwait = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model evaluated away from the active edge; it predicts the coming edge.
    always @(negedge clk) begin
        bit     exp_rdy;
        bit     exp_vld;
        bit     enq;
        bit     deq;
        bit     is_jalr;
        entry_t e;
        if (reset) begin
            sb.delete();
            m_jwait = 1'b0;
        end else begin
            exp_rdy = (sb.size() != DEPTH);
            exp_vld = (sb.size() != 0) && !m_jwait && !flush_i;
            chk("mon_if_ready", 32'(if_ready_o), 32'(exp_rdy));
            chk("mon_dec_valid", 32'(dec_valid_o), 32'(exp_vld));
            chk("mon_count", 32'(count_o), 32'(sb.size()));
            if (sb.size() == 0) begin
                chk("mon_empty_inst", dec_inst_o, 32'h00000013);
                chk("mon_empty_pc", dec_pc_o, 32'd0);
            end
            enq     = if_valid_i && exp_rdy && !flush_i;
            deq     = exp_vld && ren_ready_i;
            is_jalr = 1'b0;
            if (deq) begin
                e = sb.pop_front();
                chk("sb_pc", dec_pc_o, e.pc);
                chk("sb_inst", dec_inst_o, e.inst);
                is_jalr = (e.inst[6:0] == 7'b1100111);
            end
            if (flush_i) begin
                sb.delete();
                m_jwait = 1'b0;
            end else begin
                if (enq) begin
                    sb.push_back({if_pc_i, if_inst_i});
                end
                if (!m_jwait && deq && is_jalr) begin
                    m_jwait = 1'b1;
                end else if (m_jwait && jump_resolved_i) begin
                    m_jwait = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_valid_i = v;
        if_pc_i    = pc;
        if_inst_i  = inst;
    endtask

    // JALR then ADDI; JALR dispatches, three stalled cycles, ADDI follows the resolve pulse.
    task automatic jalr_seq();
        ren_ready_i = 1'b0;
        drive(1'b1, 32'h300, 32'h000080E7);
        cyc();
        drive(1'b1, 32'h304, 32'h00100113);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        ren_ready_i = 1'b1;
        #1;
        chk("s3_jalr_valid", 32'(dec_valid_o), 32'd1);
        chk("s3_jalr_head", dec_inst_o, 32'h000080E7);
        cyc();
        for (int k = 0; k < 3; k++) begin
            jump_resolved_i = (k == 2);
            #1;
            chk("s3_jwait_valid", 32'(dec_valid_o), 32'd0);
            cyc();
        end
        jump_resolved_i = 1'b0;
        #1;
        chk("s3_addi_valid", 32'(dec_valid_o), 32'd1);
        chk("s3_addi_head", dec_inst_o, 32'h00100113);
        cyc();
        chk("s3_count_end", 32'(count_o), 32'd0);
    endtask

    initial begin
        int idx;
        int guard;
        bit acc;

        reset           = 1'b1;
        ren_ready_i     = 1'b0;
        jump_resolved_i = 1'b0;
        flush_i         = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (3) cyc();
        chk("rst_if_ready", 32'(if_ready_o), 32'd1);
        chk("rst_dec_valid", 32'(dec_valid_o), 32'd0);
        chk("rst_dec_inst", dec_inst_o, 32'h00000013);
        chk("rst_dec_pc", dec_pc_o, 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        reset = 1'b0;
        cyc();

        // 1: single instruction, one-cycle latency, immediate dispatch
        ren_ready_i = 1'b1;
        drive(1'b1, 32'h100, 32'h00500093);
        #1;
        chk("s1_no_bypass", 32'(dec_valid_o), 32'd0);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk("s1_valid", 32'(dec_valid_o), 32'd1);
        chk("s1_pc", dec_pc_o, 32'h100);
        chk("s1_inst", dec_inst_o, 32'h00500093);
        cyc();
        chk("s1_count", 32'(count_o), 32'd0);
        chk("s1_nop", dec_inst_o, 32'h00000013);

        // 2: fill to full, backpressure, then stream 12 total with wrap
        ren_ready_i = 1'b0;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * idx), 32'h00000093 | (32'(idx) << 20));
            acc = (sb.size() != DEPTH);
            cyc();
            if (acc) idx++;
        end
        chk("s2_full_count", 32'(count_o), 32'd4);
        chk("s2_full_ready", 32'(if_ready_o), 32'd0);
        chk("s2_accepted", 32'(idx), 32'd4);
        ren_ready_i = 1'b1;
        guard = 0;
        while (idx < 12 && guard < 100) begin
            drive(1'b1, 32'h200 + 32'(4 * idx), 32'h00000093 | (32'(idx) << 20));
            acc = (sb.size() != DEPTH);
            cyc();
            if (acc) idx++;
            guard++;
        end
        chk("s2_stream_done", 32'(idx), 32'd12);
        drive(1'b0, 32'h0, 32'h0);
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            cyc();
            guard++;
        end
        chk("s2_drained", 32'(count_o), 32'd0);

        // 3: JALR serialisation
        jalr_seq();

        // 4: flush while in JWAIT with 3 buffered entries
        ren_ready_i = 1'b0;
        drive(1'b1, 32'h400, 32'h000080E7);
        cyc();
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 32'h00000013 | (32'(i) << 20));
            cyc();
        end
        drive(1'b0, 32'h0, 32'h0);
        ren_ready_i = 1'b1;
        cyc();
        chk("s4_count_jwait", 32'(count_o), 32'd3);
        chk("s4_valid_jwait", 32'(dec_valid_o), 32'd0);
        flush_i = 1'b1;
        drive(1'b1, 32'h4F0, 32'h00700093);
        #1;
        chk("s4_flush_valid", 32'(dec_valid_o), 32'd0);
        cyc();
        flush_i = 1'b0;
        drive(1'b1, 32'h480, 32'h00900093);
        #1;
        chk("s4_count_flushed", 32'(count_o), 32'd0);
        chk("s4_ready_flushed", 32'(if_ready_o), 32'd1);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk("s4_run_valid", 32'(dec_valid_o), 32'd1);
        chk("s4_run_pc", dec_pc_o, 32'h480);
        cyc();

        // 5: steady stream, one dispatch per cycle at occupancy 1
        ren_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 32'h00000113 | (32'(i) << 20));
            cyc();
            chk("s5_count", 32'(count_o), 32'd1);
            chk("s5_head_pc", dec_pc_o, 32'h500 + 32'(4 * i));
        end
        drive(1'b0, 32'h0, 32'h0);
        cyc();
        chk("s5_count_end", 32'(count_o), 32'd0);

`ifdef DECODE_DISPATCH_PERF_EN
        // 6: counters after scenario 3 from reset, unaffected by flush
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        chk("s6_dispatch_rst", perf_dispatch_o, 32'd0);
        jalr_seq();
        chk("s6_dispatch", perf_dispatch_o, 32'd2);
        chk("s6_stall", perf_jwait_stall_o, 32'd3);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        cyc();
        chk("s6_dispatch_flush", perf_dispatch_o, 32'd2);
        chk("s6_stall_flush", perf_jwait_stall_o, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_dispatch_ctrl.md
Name: decode_dispatch_ctrl

Overview:
Instruction buffer and dispatch sequencer in front of the combinational decoder.
- Accepts {pc, inst} from fetch into a DEPTH-entry FIFO.
- Presents the FIFO head to the decoder and handshakes the decoded head into rename.
- Serializes control flow: after a JALR dispatches, it holds further dispatch until the branch unit resolves the jump.
- Flushes all buffered work on a mispredict or redirect.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2.
CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridable).

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
if_valid_i  input  1  fetch presents an instruction
if_ready_o  output  1  buffer can accept this cycle
if_inst_i  input  32  fetched instruction
if_pc_i  input  32  fetched PC
dec_inst_o  output  32  head instruction, to decoder inst input
dec_pc_o  output  32  head PC, to decoder pc input
dec_jump_i  input  1  decoder jump output for the current head
dec_valid_o  output  1  decoded head valid toward rename
ren_ready_i  input  1  rename accepts this cycle
jump_resolved_i  input  1  branch unit pulse: outstanding JALR resolved
flush_i  input  1  discard all buffered instructions
count_o  output  CW  current FIFO occupancy

Behaviour:
- Reset, synchronous: both pointers 0, count 0, state RUN.
- Outputs while in reset and afterwards: if_ready_o=1, dec_valid_o=0, dec_inst_o=32'h00000013 (NOP), dec_pc_o=0, count_o=0.
- if_ready_o = (count != DEPTH). Combinational from registered count only; no dependence on ren_ready_i.
- Enqueue when if_valid_i & if_ready_o & !flush_i. Writes {pc, inst} at wr_ptr; wr_ptr wraps modulo DEPTH.
- No bypass. An accepted instruction appears at the head, with dec_valid_o high, no earlier than the next cycle. Minimum latency is 1 cycle.
- Head outputs:
  - Non-empty: dec_inst_o / dec_pc_o = entry at rd_ptr.
  - Empty: dec_inst_o = 32'h00000013, dec_pc_o = 0.
- dec_valid_o = !empty & (state==RUN) & !flush_i.
- Dequeue when dec_valid_o & ren_ready_i. rd_ptr advances with wrap.
- Count update per cycle is +1 (enqueue only), -1 (dequeue only), or unchanged (both or neither). Simultaneous enqueue and dequeue when not full is legal.
- At full, if_ready_o=0, so there is no enqueue even if a dequeue occurs that cycle.
- State machine, 2 states:
  - RUN -> JWAIT: dequeue with dec_jump_i=1 (JALR handed to rename).
  - JWAIT -> RUN: jump_resolved_i=1. dec_valid_o stays 0 in the resolving cycle and may rise the following cycle.
  - jump_resolved_i in RUN is ignored.
  - In JWAIT, enqueue continues normally until full; dec_valid_o=0.
- Flush has highest priority. In the cycle flush_i=1:
  - no enqueue and no dequeue; dec_valid_o=0;
  - next cycle: pointers 0, count 0, state RUN.
  - Flush in JWAIT also returns to RUN.
- dec_jump_i is sampled only in the dequeue cycle; its value is ignored otherwise.
- Reset overrides flush and all other inputs.

Optional Feature:
DECODE_DISPATCH_PERF_EN.
- Defined: adds two 32-bit saturating output counters. Both clear on reset only, not on flush; neither wraps.
  - perf_dispatch_o: increments on each dequeue.
  - perf_jwait_stall_o: increments each cycle with state==JWAIT and count!=0.
- Undefined: both ports and their registers are absent. All other behaviour is identical.

Test Plan:
1. Reset, then single enqueue of pc=0x100, inst=0x00500093 with ren_ready_i=1 -> dec_valid_o rises the next cycle with that head; dequeued that cycle; count returns to 0; dec_inst_o returns to 0x00000013.
2. Enqueue 5 back-to-back instructions with DEPTH=4 and ren_ready_i=0 -> if_ready_o drops after the 4th; count_o=4; the 5th is held by fetch. Release ren_ready_i -> strict FIFO order; pointers wrap correctly over 12 total instructions.
3. Head JALR inst=0x000080E7 with dec_jump_i=1 dispatched, followed by ADDI -> state JWAIT; dec_valid_o=0 for 3 cycles; jump_resolved_i pulse -> ADDI dispatched the cycle after the pulse.
4. FIFO holding 3 entries in JWAIT; flush_i with simultaneous if_valid_i -> next cycle count_o=0, state RUN, flushed-cycle instruction not stored.
5. Steady stream with if_valid_i=1 and ren_ready_i=1 each cycle -> one dispatch per cycle after a 1-cycle fill; count_o stays 1.
6. With DECODE_DISPATCH_PERF_EN, run scenario 3 -> perf_dispatch_o=2 and perf_jwait_stall_o=3; a later flush leaves both values unchanged.
